// File: rtl/pwm_voice_if.sv
// Register-file to tone-generator bundle: eight voice control words in, waveform/mix/DAC bits out.
interface pwm_voice_if;
  logic [15:0] pwm_reg0;
  logic [15:0] pwm_reg1;
  logic [15:0] pwm_reg2;
  logic [15:0] pwm_reg3;
  logic [15:0] pwm_reg4;
  logic [15:0] pwm_reg5;
  logic [15:0] pwm_reg6;
  logic [15:0] pwm_reg7;
  logic [7:0]  voice;
  logic [3:0]  level;
  logic        audio_pwm;

  modport master (
    output pwm_reg0, pwm_reg1, pwm_reg2, pwm_reg3,
    output pwm_reg4, pwm_reg5, pwm_reg6, pwm_reg7,
    input  voice, level, audio_pwm
  );

  modport slave (
    input  pwm_reg0, pwm_reg1, pwm_reg2, pwm_reg3,
    input  pwm_reg4, pwm_reg5, pwm_reg6, pwm_reg7,
    output voice, level, audio_pwm
  );
endinterface

// File: rtl/pwm_voice_gen.sv
// Eight-voice square-wave tone generator, popcount mixer and 1-bit PWM DAC.
module pwm_voice_gen #(
  parameter int unsigned PRESCALE = 50
) (
  input logic        clk,
  input logic        rst,
  pwm_voice_if.slave bus
);

  logic [15:0] regs [8];
  logic [15:0] pre_cnt_q;
  logic        tick;
  logic [14:0] hp_q  [8];
  logic [14:0] cnt_q [8];
  logic [7:0]  voice_q;
  logic [3:0]  level_d, level_q;
  logic [2:0]  dac_cnt_q;
  logic        audio_pwm_q;

  assign regs[0] = bus.pwm_reg0;
  assign regs[1] = bus.pwm_reg1;
  assign regs[2] = bus.pwm_reg2;
  assign regs[3] = bus.pwm_reg3;
  assign regs[4] = bus.pwm_reg4;
  assign regs[5] = bus.pwm_reg5;
  assign regs[6] = bus.pwm_reg6;
  assign regs[7] = bus.pwm_reg7;

  assign tick = (pre_cnt_q == 16'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= tick ? '0 : pre_cnt_q + 16'd1;
    end
  end

  // New half-periods are only sampled when idle or at a toggle, so a half-cycle never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voice_q <= '0;
      for (int n = 0; n < 8; n++) begin
        hp_q[n]  <= '0;
        cnt_q[n] <= '0;
      end
    end else if (tick) begin
      for (int n = 0; n < 8; n++) begin
        if (!regs[n][15] || (hp_q[n] == '0)) begin
          voice_q[n] <= 1'b0;
          cnt_q[n]   <= '0;
          hp_q[n]    <= regs[n][14:0];
        end else if (cnt_q[n] >= hp_q[n] - 15'd1) begin
          voice_q[n] <= ~voice_q[n];
          cnt_q[n]   <= '0;
          hp_q[n]    <= regs[n][14:0];
        end else begin
          cnt_q[n]   <= cnt_q[n] + 15'd1;
        end
      end
    end
  end

  always_comb begin
    level_d = '0;
    for (int i = 0; i < 8; i++) begin
      level_d = level_d + 4'(voice_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q     <= '0;
      dac_cnt_q   <= '0;
      audio_pwm_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      dac_cnt_q   <= dac_cnt_q + 3'd1;
      audio_pwm_q <= ({1'b0, dac_cnt_q} < level_q);
    end
  end

  assign bus.voice     = voice_q;
  assign bus.level     = level_q;
  assign bus.audio_pwm = audio_pwm_q;

endmodule

// File: tb/tb_pwm_voice_gen.sv
// Directed bench for pwm_voice_gen with PRESCALE=4 (tick on every 4th posedge after reset release).
module tb_pwm_voice_gen;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   hi_cnt;

  pwm_voice_if bus ();

  pwm_voice_gen #(
    .PRESCALE(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance n posedges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] v);
    bus.pwm_reg0 = v; bus.pwm_reg1 = v; bus.pwm_reg2 = v; bus.pwm_reg3 = v;
    bus.pwm_reg4 = v; bus.pwm_reg5 = v; bus.pwm_reg6 = v; bus.pwm_reg7 = v;
  endtask

  // Release lands on a negedge so posedge k after release is the k-th counted edge.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic count_audio(input int n);
    hi_cnt = 0;
    repeat (n) begin
      step(1);
      if (bus.audio_pwm === 1'b1) hi_cnt++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    set_all(16'h0000);
    step(2);
    check("rst_voice", 32'(bus.voice), 32'h00);
    check("rst_level", 32'(bus.level), 32'h0);
    check("rst_audio", 32'(bus.audio_pwm), 32'h0);

    // T1: voice0 half-period 3 ticks = 12 clk; first toggle at posedge 16
    bus.pwm_reg0 = 16'h8003;
    do_reset();
    step(15);
    check("t1_pre_toggle", 32'(bus.voice), 32'h00);
    step(1);
    check("t1_rise16", 32'(bus.voice), 32'h01);
    check("t1_level_lag", 32'(bus.level), 32'h0);
    step(1);
    check("t1_level17", 32'(bus.level), 32'h1);
    step(10);
    check("t1_high27", 32'(bus.voice), 32'h01);
    step(1);
    check("t1_fall28", 32'(bus.voice), 32'h00);
    step(1);
    check("t1_level29", 32'(bus.level), 32'h0);
    step(11);
    check("t1_rise40", 32'(bus.voice), 32'h01);

    // T6: asynchronous reset between edges, then T1 timing from the start
    step(3);
    check("t6_pre_voice", 32'(bus.voice), 32'h01);
    check("t6_pre_level", 32'(bus.level), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_voice", 32'(bus.voice), 32'h00);
    check("t6_async_level", 32'(bus.level), 32'h0);
    check("t6_async_audio", 32'(bus.audio_pwm), 32'h0);
    do_reset();
    step(15);
    check("t6_pre_toggle", 32'(bus.voice), 32'h00);
    step(1);
    check("t6_rise16", 32'(bus.voice), 32'h01);
    step(12);
    check("t6_fall28", 32'(bus.voice), 32'h00);

    // T4: 10-tick half-period finishes despite switching to 2 at cnt=5
    set_all(16'h0000);
    bus.pwm_reg0 = 16'h800A;
    do_reset();
    step(24);
    bus.pwm_reg0 = 16'h8002;
    step(19);
    check("t4_old_len43", 32'(bus.voice), 32'h00);
    step(1);
    check("t4_toggle44", 32'(bus.voice), 32'h01);
    step(7);
    check("t4_high51", 32'(bus.voice), 32'h01);
    step(1);
    check("t4_new_len52", 32'(bus.voice), 32'h00);
    step(8);
    check("t4_rise60", 32'(bus.voice), 32'h01);

    // T5: clearing enable forces low on the next tick; en with hp=0 stays idle
    step(1);
    bus.pwm_reg0 = 16'h0002;
    step(2);
    check("t5_hold63", 32'(bus.voice), 32'h01);
    step(1);
    check("t5_off64", 32'(bus.voice), 32'h00);
    bus.pwm_reg0 = 16'h8000;
    step(40);
    check("t5_hp0_idle", 32'(bus.voice), 32'h00);

    // T2: eight voices in phase, level alternates 8/0
    set_all(16'h8002);
    do_reset();
    step(13);
    check("t2_voice_all", 32'(bus.voice), 32'hFF);
    check("t2_level8", 32'(bus.level), 32'h8);
    count_audio(8);
    check("t2_audio_full", 32'(hi_cnt), 32'd8);
    check("t2_level0", 32'(bus.level), 32'h0);
    check("t2_voice_none", 32'(bus.voice), 32'h00);
    count_audio(8);
    check("t2_audio_none", 32'(hi_cnt), 32'd0);
    check("t2_level8_again", 32'(bus.level), 32'h8);

    // T3: three voices held high for 20 clk; audio high 3 of each 8 clk
    set_all(16'h0000);
    bus.pwm_reg0 = 16'h8005;
    bus.pwm_reg1 = 16'h8005;
    bus.pwm_reg2 = 16'h8005;
    do_reset();
    step(29);
    check("t3_voice", 32'(bus.voice), 32'h07);
    check("t3_level3", 32'(bus.level), 32'h3);
    count_audio(8);
    check("t3_duty_a", 32'(hi_cnt), 32'd3);
    count_audio(8);
    check("t3_duty_b", 32'(hi_cnt), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
